// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// The EX side is the master; the divider is the slave.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ready_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output annul_i,
        input  busy_o,
        input  ready_o,
        input  result_o,
        input  div_by_zero_o
    );

    modport slave (
        input  start_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  annul_i,
        output busy_o,
        output ready_o,
        output result_o,
        output div_by_zero_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider resolving STEPS quotient bits per cycle.
// Result is {remainder, quotient}; all outputs come from registers.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic       clk,
    input  logic       reset,
    div_iter_if.slave  bus
);
    localparam int K  = WIDTH / STEPS;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (WIDTH < 4 || (WIDTH % STEPS) != 0 ||
        !(STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8)) begin : g_bad_cfg
        $error("div_iter: illegal WIDTH/STEPS combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shq_q, shq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     trial_v, diff_v;
    logic [WIDTH-1:0]   step_rem, step_shq;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

    // shq holds the unconsumed dividend bits in its top and collects
    // quotient bits at the bottom; the remainder stays below the divisor,
    // so the trial's top bit is a reliable borrow.
    always_comb begin
        step_rem = rem_q;
        step_shq = shq_q;
        trial_v  = '0;
        diff_v   = '0;
        for (int i = 0; i < STEPS; i++) begin
            trial_v  = {step_rem, step_shq[WIDTH-1]};
            diff_v   = trial_v - {1'b0, dvs_q};
            step_shq = {step_shq[WIDTH-2:0], ~diff_v[WIDTH]};
            step_rem = diff_v[WIDTH] ? trial_v[WIDTH-1:0]
                                     : diff_v[WIDTH-1:0];
        end
    end

    assign q_fix = qneg_q ? -step_shq : step_shq;
    assign r_fix = rneg_q ? -step_rem : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shq_d    = shq_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        dz_d     = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    shq_d  = a_neg ? -bus.opdata1_i : bus.opdata1_i;
                    dvs_d  = b_neg ? -bus.opdata2_i : bus.opdata2_i;
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (bus.opdata2_i == '0) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        dz_d     = 1'b1;
                    end else begin
                        state_d  = S_ON;
                    end
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    shq_d = step_shq;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d  = S_DONE;
                        result_d = {r_fix, q_fix};
                        dz_d     = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shq_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shq_q    <= shq_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy_o        = (state_q == S_ON);
    assign bus.ready_o       = (state_q == S_DONE);
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dz_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter in three configurations (32/1, 32/4, 16/2).
// Expected results are queued at issue and checked when ready_o rises.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = '0;
    logic [2:0]  an  = '0;
    logic        sg  = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    int          sel = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) if0 ();
    div_iter_if #(.WIDTH(32)) if1 ();
    div_iter_if #(.WIDTH(16)) if2 ();

    assign if0.start_i      = st[0];
    assign if0.annul_i      = an[0];
    assign if0.signed_div_i = sg;
    assign if0.opdata1_i    = op1;
    assign if0.opdata2_i    = op2;
    assign if1.start_i      = st[1];
    assign if1.annul_i      = an[1];
    assign if1.signed_div_i = sg;
    assign if1.opdata1_i    = op1;
    assign if1.opdata2_i    = op2;
    assign if2.start_i      = st[2];
    assign if2.annul_i      = an[2];
    assign if2.signed_div_i = sg;
    assign if2.opdata1_i    = op1[15:0];
    assign if2.opdata2_i    = op2[15:0];

    div_iter #(.WIDTH(32), .STEPS(1)) u0 (.clk(clk), .reset(rst), .bus(if0.slave));
    div_iter #(.WIDTH(32), .STEPS(4)) u1 (.clk(clk), .reset(rst), .bus(if1.slave));
    div_iter #(.WIDTH(16), .STEPS(2)) u2 (.clk(clk), .reset(rst), .bus(if2.slave));

    logic        rdy_s, busy_s, dz_s;
    logic [63:0] res_s;
    assign rdy_s  = sel == 0 ? if0.ready_o : sel == 1 ? if1.ready_o : if2.ready_o;
    assign busy_s = sel == 0 ? if0.busy_o  : sel == 1 ? if1.busy_o  : if2.busy_o;
    assign dz_s   = sel == 0 ? if0.div_by_zero_o :
                    sel == 1 ? if1.div_by_zero_o : if2.div_by_zero_o;
    assign res_s  = sel == 0 ? if0.result_o : sel == 1 ? if1.result_o :
                    {32'h0, if2.result_o};

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int kof(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Reference division independent of the bit-serial algorithm.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, q, r;
        if (b == 32'h0) return 64'h0;
        if (!sgn) return {a % b, a / b};
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        q   = sa / sb2;
        r   = sa % sb2;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] eres, input bit edz, input int hold);
        exp_t e, g;
        int   n;
        bit   seen;
        e.res = eres;
        e.dz  = edz;
        e.lat = edz ? 1 : kof(d) + 1;
        sb.push_back(e);
        sel = d; sg = sgn; op1 = a; op2 = b; st[d] = 1'b1;
        tick();
        op1 = ~a; op2 = b ^ 32'h5; sg = ~sgn;
        seen = 1'b0;
        n = 1;
        while (n <= 100) begin
            if (rdy_s) begin
                seen = 1'b1;
                break;
            end
            chk("busy_on", busy_s, 1'b1);
            tick();
            n++;
        end
        chk("ready_seen", seen, 1'b1);
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) g = sb.pop_front();
        if (seen) begin
            chk("latency", n, g.lat);
            chk("result", res_s, g.res);
            chk("dz", dz_s, g.dz);
            chk("busy_done", busy_s, 1'b0);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("ready_hold", rdy_s, 1'b1);
                chk("result_hold", res_s, g.res);
            end
        end
        st[d] = 1'b0;
        tick();
        chk("ready_drop", rdy_s, 1'b0);
        chk("result_idle", res_s, g.res);
        chk("dz_idle", dz_s, g.dz);
        tick();
    endtask

    task automatic all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #0;
            chk({tag, "_busy"}, busy_s, 1'b0);
            chk({tag, "_ready"}, rdy_s, 1'b0);
            chk({tag, "_result"}, res_s, 64'h0);
            chk({tag, "_dz"}, dz_s, 1'b0);
        end
        sel = 0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs, hit;

        #2;
        all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        run(0, 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, 3);
        run(0, 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);
        run(0, 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 0);
        run(0, 1'b0, 32'd5, 32'd0, 64'h0, 1'b1, 1);
        run(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0);

        sel = 0; op1 = 32'd9; op2 = 32'd3; sg = 1'b0;
        st[0] = 1'b1; an[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_annul_busy", busy_s, 1'b0);
            chk("idle_annul_ready", rdy_s, 1'b0);
        end
        an[0] = 1'b0;
        tick();
        for (int c = 1; c < 10; c++) tick();
        chk("annul_busy_c10", busy_s, 1'b1);
        an[0] = 1'b1;
        tick();
        chk("annul_busy_c11", busy_s, 1'b0);
        chk("annul_ready_c11", rdy_s, 1'b0);
        an[0] = 1'b0; st[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rdy_s) hit = 1'b1;
        end
        chk("annul_no_ready", hit, 1'b0);
        chk("annul_result_kept", res_s, 64'h00000000_80000000);

        run(0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 0);

        op1 = 32'd20; op2 = 32'd4; sg = 1'b0; st[0] = 1'b1;
        tick();
        for (int c = 1; c < 32; c++) tick();
        chk("last_on_busy", busy_s, 1'b1);
        an[0] = 1'b1;
        tick();
        chk("last_annul_ready", rdy_s, 1'b0);
        chk("last_annul_busy", busy_s, 1'b0);
        chk("last_annul_result", res_s, 64'h00000002_0000000E);
        an[0] = 1'b0; st[0] = 1'b0;
        tick();

        op1 = 32'd50; op2 = 32'd5; st[0] = 1'b1;
        tick();
        for (int c = 1; c < 5; c++) tick();
        chk("pre_reset_busy", busy_s, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_busy", busy_s, 1'b0);
        chk("mid_reset_ready", rdy_s, 1'b0);
        chk("mid_reset_result", res_s, 64'h0);
        chk("mid_reset_dz", dz_s, 1'b0);
        tick();
        st[0] = 1'b0; rst = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rdy_s || busy_s) hit = 1'b1;
        end
        chk("post_reset_quiet", hit, 1'b0);

        run(1, 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b0, 0);
        run(2, 1'b1, 32'h00008000, 32'h3, 64'h00000000_FFFED556, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
            rs = 1'(i % 2);
            run(1, rs, ra, rb, model(rs, ra, rb), rb == 32'h0, i % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative restoring divider for the execute stage. It generalises the fixed 32-bit, 1-bit-per-cycle divider with four additions: configurable operand width, configurable quotient bits resolved per cycle, an explicit divide-by-zero flag, and a busy indication. It sits beside the EX stage. The EX stage holds `start_i` and stalls while `busy_o` is high. `result_o` feeds HI/LO writeback as {remainder, quotient}.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 4.
- `STEPS`, 1: quotient bits resolved per cycle. Must divide `WIDTH` evenly. Legal values are 1, 2, 4 and 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request. Held high by EX until the result is taken.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with `start_i`.
- `opdata1_i`  in  WIDTH  dividend, sampled with `start_i`.
- `opdata2_i`  in  WIDTH  divisor, sampled with `start_i`.
- `annul_i`  in  1  abort (exception flush).
- `busy_o`  out  1  high while state is ON.
- `ready_o`  out  1  result valid; high only in state DONE.
- `result_o`  out  2*WIDTH  {remainder, quotient}.
- `div_by_zero_o`  out  1  set when the latched divisor was 0; valid when `ready_o` is high.

## Operation
- States: IDLE, ON, DONE.
- IDLE:
  - On `start_i & ~annul_i`, latch the operands and `signed_div_i`.
  - If the divisor is 0, go to DONE with `result_o`=0 and `div_by_zero_o`=1.
  - Otherwise go to ON and clear the iteration counter.
- Signed mode: divide the magnitudes |dividend| and |divisor|. Each magnitude is a WIDTH-bit unsigned value, so |−2^(WIDTH−1)| = 2^(WIDTH−1).
- ON, per cycle: perform `STEPS` restoring steps on a (WIDTH+1)-bit partial remainder.
  - Each step shifts in the next dividend bit.
  - Trial-subtract the divisor; keep the difference if it is non-negative.
  - Shift the quotient bit in.
- ON exit: after WIDTH/`STEPS` cycles, go to DONE and apply the sign fix:
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend;
  - with `signed_div_i`=0, no fix is applied.
- Overflow case: signed −2^(WIDTH−1) / −1 yields quotient 0x80..0 and remainder 0, with no flag.
- DONE: `ready_o`=1 and `result_o` is stable. Return to IDLE when `start_i` drops or `annul_i`=1.
- Result hold: `result_o` and `div_by_zero_o` hold their values in IDLE until the next accepted start.
- `annul_i` in ON: go to IDLE next edge. `ready_o` is never asserted for that operation and `result_o` keeps its previous value.
- `annul_i` in IDLE overrides `start_i`: the request is not accepted.
- Operand inputs changing after acceptance have no effect.
- A new start is accepted only from IDLE, i.e. at least one IDLE cycle follows every DONE.

## Timing
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - `busy_o`=0, `ready_o`=0, `result_o`=0, `div_by_zero_o`=0;
  - the counter and partial remainder are cleared.
- Reset mid-operation discards the operation; no `ready_o` follows.
- Start accepted at edge 0 (end of IDLE cycle): `busy_o`=1 during cycles 1..K, where K = WIDTH/`STEPS`.
- `ready_o` first high in cycle K+1. Latency by configuration:
  - WIDTH=32, STEPS=1: 33 cycles.
  - WIDTH=32, STEPS=4: 9 cycles.
  - Divide by zero: `ready_o` in cycle 1, `busy_o` never high.
- `ready_o` remains high each cycle `start_i` stays high. It drops in the cycle after `start_i` is seen low.
- Annul in ON cycle n: `busy_o`=0 from cycle n+1.
- Simultaneous `annul_i` and the final ON cycle: annul wins, and `ready_o` stays 0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned basic: WIDTH=32, STEPS=1, 7/2 unsigned → `ready_o` first high in cycle 33; `result_o`={0x00000001, 0x00000003}; `busy_o` high in cycles 1..32.
- Signed fix: 0xFFFFFFF9 / 0x00000002 signed → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero and overflow:
  - 5/0 → `ready_o` in cycle 1, `div_by_zero_o`=1, `result_o`=0.
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0, flag 0.
- Annul mid-operation: annul in cycle 10 → `busy_o`=0 in cycle 11, `ready_o` never asserted, `result_o` unchanged. The next start (100/7) → {2, 14} in cycle 33 after acceptance.
- Parametrisation: STEPS=4, 0xFFFFFFFF / 0x10 unsigned → {0xF, 0x0FFFFFFF} with `ready_o` in cycle 9. WIDTH=16, STEPS=2, 0x8000 / 0x0003 signed → {0xFFFE, 0xD556} in cycle 9.
- Reset and handshake:
  - Assert `reset` in ON cycle 5 → all outputs 0 immediately; after release, no `ready_o`.
  - Hold `start_i` 3 cycles past DONE → `ready_o` high for all 3 cycles.
  - Drop `start_i` → IDLE next edge; `result_o` holds its value.
